burst_cons: RTL and testbench



---
 rtl/burst_cons_pkg.sv | 35 +++
 rtl/burst_cons_if.sv | 51 +++++
 rtl/burst_cons_acc.sv | 94 +++++++++
 rtl/burst_cons.sv | 137 +++++++++++++
 tb/tb_burst_cons.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/burst_cons_pkg.sv
// Shared definitions for the lab8 burst stream: FSM state type, field widths,
// length saturation point and the default legal burst-length window (3..5)
// that the producer and the consumer both use.
package burst_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } burst_state_e;

    localparam int LEN_W       = 4;
    localparam int LEN_SAT     = 15;
    localparam int DATA_W      = 8;
    localparam int MIN_LEN_DEF = 3;
    localparam int MAX_LEN_DEF = 5;

    // Larger of two bytes.
    function automatic logic [DATA_W-1:0] byte_max(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        if (a > b) begin
            r = a;
        end else begin
            r = b;
        end
        return r;
    endfunction

    // One step of the running XOR check byte.
    function automatic logic [DATA_W-1:0] chk_fold(input logic [DATA_W-1:0] acc,
                                                  input logic [DATA_W-1:0] d);
        return acc ^ d;
    endfunction

endpackage

// File: rtl/burst_cons_if.sv
// Producer -> consumer burst stream plus the consumer's report bus.
// Optional check byte rpt_chk is present when BURST_CONS_CHK_EN is defined.
interface burst_cons_if #(
    parameter int SUM_W = 12,
    parameter int CNT_W = 16
);
    import burst_pkg::*;

    logic              val;
    logic [DATA_W-1:0] data;
    logic              rpt_val;
    logic [LEN_W-1:0]  rpt_len;
    logic [SUM_W-1:0]  rpt_sum;
    logic [DATA_W-1:0] rpt_max;
    logic              rpt_err;
    logic [CNT_W-1:0]  burst_cnt;
`ifdef BURST_CONS_CHK_EN
    logic [DATA_W-1:0] rpt_chk;
`endif

    // Producer side: drives the stream, observes reports.
    modport master (
        output val,
        output data,
`ifdef BURST_CONS_CHK_EN
        input  rpt_chk,
`endif
        input  rpt_val,
        input  rpt_len,
        input  rpt_sum,
        input  rpt_max,
        input  rpt_err,
        input  burst_cnt
    );

    // Consumer side: samples the stream, drives reports.
    modport slave (
        input  val,
        input  data,
`ifdef BURST_CONS_CHK_EN
        output rpt_chk,
`endif
        output rpt_val,
        output rpt_len,
        output rpt_sum,
        output rpt_max,
        output rpt_err,
        output burst_cnt
    );

endinterface

// File: rtl/burst_cons_acc.sv
// burst_acc: per-burst accumulator (length, saturating byte sum, max byte and,
// with BURST_CONS_CHK_EN, XOR check byte). load starts a new burst with the
// current byte, acc folds the current byte in. Once the length reaches its
// saturation point the burst statistics freeze, so a report always describes
// the first 15 bytes of an over-long burst (15 x 255 still fits the sum).
module burst_acc
    import burst_pkg::*;
#(
    parameter int SUM_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              acc,
    input  logic [DATA_W-1:0] data,
`ifdef BURST_CONS_CHK_EN
    output logic [DATA_W-1:0] chk,
`endif
    output logic [LEN_W-1:0]  len,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max
);

    localparam logic [LEN_W-1:0] LEN_SAT_V = LEN_W'(LEN_SAT);

    logic [LEN_W-1:0]  len_r,  len_nxt_s;
    logic [SUM_W-1:0]  sum_r,  sum_nxt_s;
    logic [DATA_W-1:0] max_r,  max_nxt_s;
    logic [SUM_W:0]    sum_ext_s;
`ifdef BURST_CONS_CHK_EN
    logic [DATA_W-1:0] chk_r,  chk_nxt_s;
`endif

    // Next-state of the accumulators: load, saturating accumulate, or hold.
    always_comb begin
        len_nxt_s = len_r;
        sum_nxt_s = sum_r;
        max_nxt_s = max_r;
`ifdef BURST_CONS_CHK_EN
        chk_nxt_s = chk_r;
`endif
        sum_ext_s = {1'b0, sum_r} + {{(SUM_W + 1 - DATA_W){1'b0}}, data};
        if (load) begin
            len_nxt_s = {{(LEN_W - 1){1'b0}}, 1'b1};
            sum_nxt_s = {{(SUM_W - DATA_W){1'b0}}, data};
            max_nxt_s = data;
`ifdef BURST_CONS_CHK_EN
            chk_nxt_s = data;
`endif
        end else if (acc && (len_r != LEN_SAT_V)) begin
            len_nxt_s = len_r + {{(LEN_W - 1){1'b0}}, 1'b1};
            if (sum_ext_s[SUM_W]) begin
                sum_nxt_s = {SUM_W{1'b1}};
            end else begin
                sum_nxt_s = sum_ext_s[SUM_W-1:0];
            end
            max_nxt_s = byte_max(max_r, data);
`ifdef BURST_CONS_CHK_EN
            chk_nxt_s = chk_fold(chk_r, data);
`endif
        end else begin
            len_nxt_s = len_r;
            sum_nxt_s = sum_r;
            max_nxt_s = max_r;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r <= {LEN_W{1'b0}};
            sum_r <= {SUM_W{1'b0}};
            max_r <= {DATA_W{1'b0}};
`ifdef BURST_CONS_CHK_EN
            chk_r <= {DATA_W{1'b0}};
`endif
        end else begin
            len_r <= len_nxt_s;
            sum_r <= sum_nxt_s;
            max_r <= max_nxt_s;
`ifdef BURST_CONS_CHK_EN
            chk_r <= chk_nxt_s;
`endif
        end
    end

    assign len = len_r;
    assign sum = sum_r;
    assign max = max_r;
`ifdef BURST_CONS_CHK_EN
    assign chk = chk_r;
`endif

endmodule

// File: rtl/burst_cons.sv
// burst_cons: consumer end of the lab8 val/data burst stream. Samples every
// cycle, accumulates per-burst statistics and emits a one-cycle registered
// summary report the cycle after the burst's first idle sample, flagging
// bursts whose length lies outside MIN_LEN..MAX_LEN. A new burst may start in
// the same cycle as the report of the previous one.
// Optional feature macro: BURST_CONS_CHK_EN adds rpt_chk (XOR of burst bytes).
module burst_cons
    import burst_pkg::*;
#(
    parameter int MIN_LEN = MIN_LEN_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int SUM_W   = 12,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    burst_cons_if.slave  bus
);

    localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    burst_state_e      state_r, state_nxt_s;
    logic              load_s, acc_s, fire_s, err_s;
    logic [LEN_W-1:0]  acc_len_s;
    logic [SUM_W-1:0]  acc_sum_s;
    logic [DATA_W-1:0] acc_max_s;

    logic              rpt_val_r;
    logic [LEN_W-1:0]  rpt_len_r;
    logic [SUM_W-1:0]  rpt_sum_r;
    logic [DATA_W-1:0] rpt_max_r;
    logic              rpt_err_r;
    logic [CNT_W-1:0]  burst_cnt_r;
`ifdef BURST_CONS_CHK_EN
    logic [DATA_W-1:0] acc_chk_s;
    logic [DATA_W-1:0] rpt_chk_r;
`endif

    burst_acc #(
        .SUM_W (SUM_W)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .acc  (acc_s),
        .data (bus.data),
`ifdef BURST_CONS_CHK_EN
        .chk  (acc_chk_s),
`endif
        .len  (acc_len_s),
        .sum  (acc_sum_s),
        .max  (acc_max_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and accumulator/report controls.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        acc_s       = 1'b0;
        fire_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.val) begin
                    load_s      = 1'b1;
                    state_nxt_s = RECV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RECV: begin
                if (bus.val) begin
                    acc_s       = 1'b1;
                    state_nxt_s = RECV;
                end else begin
                    fire_s      = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Length-window check on the finished burst.
    always_comb begin
        err_s = (acc_len_s < MIN_LEN_V) || (acc_len_s > MAX_LEN_V);
    end

    // Report registers: pulse rpt_val, capture fields, count bursts; fields hold between reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_val_r   <= 1'b0;
            rpt_len_r   <= {LEN_W{1'b0}};
            rpt_sum_r   <= {SUM_W{1'b0}};
            rpt_max_r   <= {DATA_W{1'b0}};
            rpt_err_r   <= 1'b0;
            burst_cnt_r <= {CNT_W{1'b0}};
`ifdef BURST_CONS_CHK_EN
            rpt_chk_r   <= {DATA_W{1'b0}};
`endif
        end else begin
            rpt_val_r <= fire_s;
            if (fire_s) begin
                rpt_len_r   <= acc_len_s;
                rpt_sum_r   <= acc_sum_s;
                rpt_max_r   <= acc_max_s;
                rpt_err_r   <= err_s;
                burst_cnt_r <= burst_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
`ifdef BURST_CONS_CHK_EN
                rpt_chk_r   <= acc_chk_s;
`endif
            end
        end
    end

    assign bus.rpt_val   = rpt_val_r;
    assign bus.rpt_len   = rpt_len_r;
    assign bus.rpt_sum   = rpt_sum_r;
    assign bus.rpt_max   = rpt_max_r;
    assign bus.rpt_err   = rpt_err_r;
    assign bus.burst_cnt = burst_cnt_r;
`ifdef BURST_CONS_CHK_EN
    assign bus.rpt_chk   = rpt_chk_r;
`endif

endmodule

// File: tb/tb_burst_cons.sv
// Scoreboard bench for burst_cons: the driver models each burst as it is sent
// and queues the expected report; a negedge monitor pops and compares.
module tb_burst_cons;

    typedef struct {
        int due;
        int len;
        int sum;
        int max;
        int err;
        int cnt;
        int chk;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_bad;
    exp_t sb[$];
    exp_t last_e;
    bit   have_last;

    bit   m_in;
    int   m_len, m_sum, m_max, m_chk, m_cnt;

    burst_cons_if bus ();

    burst_cons dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid cycle; the model follows the same rules the consumer is specified with.
    task automatic send(input int b);
        bus.val  = 1'b1;
        bus.data = 8'(b);
        if (!m_in) begin
            m_in  = 1'b1;
            m_len = 1;
            m_sum = b;
            m_max = b;
            m_chk = b;
        end else if (m_len < 15) begin
            m_len = m_len + 1;
            m_sum = (m_sum + b > 4095) ? 4095 : m_sum + b;
            m_max = (b > m_max) ? b : m_max;
            m_chk = m_chk ^ b;
        end
        tick();
    endtask

    // Idle cycles with junk data; the first idle after a burst queues its report.
    task automatic idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            bus.val  = 1'b0;
            bus.data = 8'($urandom_range(255, 0));
            if (m_in) begin
                m_in  = 1'b0;
                m_cnt = m_cnt + 1;
                e.due = cyc + 1;
                e.len = m_len;
                e.sum = m_sum;
                e.max = m_max;
                e.err = (m_len < 3 || m_len > 5) ? 1 : 0;
                e.cnt = m_cnt % 65536;
                e.chk = m_chk;
                sb.push_back(e);
            end
            tick();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk_eq({tag, "_val"}, 32'(bus.rpt_val), 32'd0);
        chk_eq({tag, "_len"}, 32'(bus.rpt_len), 32'd0);
        chk_eq({tag, "_sum"}, 32'(bus.rpt_sum), 32'd0);
        chk_eq({tag, "_max"}, 32'(bus.rpt_max), 32'd0);
        chk_eq({tag, "_err"}, 32'(bus.rpt_err), 32'd0);
        chk_eq({tag, "_cnt"}, 32'(bus.burst_cnt), 32'd0);
`ifdef BURST_CONS_CHK_EN
        chk_eq({tag, "_chk"}, 32'(bus.rpt_chk), 32'd0);
`endif
    endtask

    // Report monitor: every rpt_val must match the head of the scoreboard; fields hold otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.rpt_val === 1'b1) begin
                if (sb.size() == 0) begin
                    chk_eq("rpt_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk_eq("rpt_cycle", 32'(cyc), 32'(e.due));
                    chk_eq("rpt_len", 32'(bus.rpt_len), 32'(e.len));
                    chk_eq("rpt_sum", 32'(bus.rpt_sum), 32'(e.sum));
                    chk_eq("rpt_max", 32'(bus.rpt_max), 32'(e.max));
                    chk_eq("rpt_err", 32'(bus.rpt_err), 32'(e.err));
                    chk_eq("burst_cnt", 32'(bus.burst_cnt), 32'(e.cnt));
`ifdef BURST_CONS_CHK_EN
                    chk_eq("rpt_chk", 32'(bus.rpt_chk), 32'(e.chk));
`endif
                    last_e    = e;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk_eq("hold_len", 32'(bus.rpt_len), 32'(last_e.len));
                chk_eq("hold_sum", 32'(bus.rpt_sum), 32'(last_e.sum));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        m_in = 1'b0; m_cnt = 0; m_len = 0; m_sum = 0; m_max = 0; m_chk = 0;
        have_last = 1'b0;
        bus.val = 1'b0; bus.data = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        chk_zero_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Basic legal burst.
        send(8'h10); send(8'h20); send(8'h30);
        idle(3);

        // Max-length burst, one idle cycle, then a new burst back to back.
        for (int i = 0; i < 5; i++) send(8'hFF);
        idle(1);
        for (int i = 0; i < 3; i++) send(8'h01);
        idle(3);

        // Single-cycle burst: legal to receive, flagged as error.
        send(8'h7A);
        idle(3);

        // Check-byte pattern.
        send(8'hA5); send(8'h5A); send(8'h0F);
        idle(2);

        // Over-long burst: length saturates at 15, one report only.
        for (int i = 0; i < 20; i++) send(8'hFF);
        idle(4);

        // Producer-like traffic: bursts of 3..5, gaps of 1..4.
        for (int k = 0; k < 300; k++) begin
            int n;
            n = $urandom_range(5, 3);
            for (int i = 0; i < n; i++) send($urandom_range(255, 0));
            idle($urandom_range(4, 1));
        end
        idle(3);
        chk_eq("sb_drain_pre_reset", 32'(sb.size()), 32'd0);

        // Reset on the second cycle of a burst: discard, clear, no report.
        send(8'h11);
        bus.val  = 1'b1;
        bus.data = 8'h22;
        #2;
        rst = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        m_in = 1'b0;
        m_cnt = 0;
        have_last = 1'b0;
        @(posedge clk); #1;
        bus.val = 1'b0;
        tick();
        rst = 1'b0;
        idle(6);
        chk_eq("cnt_after_rst", 32'(bus.burst_cnt), 32'd0);

        // Traffic resumes after reset with a fresh count.
        send(8'h03); send(8'h04); send(8'h05); send(8'h06);
        idle(4);

        chk_eq("sb_drain", 32'(sb.size()), 32'd0);
        chk_eq("cnt_final", 32'(bus.burst_cnt), 32'(m_cnt));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
